// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester and APB bus signals for apb_master_arbiter
interface apb_master_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic [ADDR_W-1:0]      Paddr;
    logic                   Pwrite;
    logic [DATA_W-1:0]      Pwdata;
    logic                   Psel;
    logic                   Penable;
    logic [DATA_W-1:0]      Prdata;
    logic                   Pready;
    logic                   Pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, Paddr, Pwrite, Pwdata, Psel, Penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, Paddr, Pwrite, Pwdata, Psel, Penable
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin APB master shared by NREQ requesters; APB_TIMEOUT_EN adds an ACCESS wait timeout
module apb_master_arbiter #(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                Pclk,
    input  logic                Prst,
    apb_master_arbiter_if.master bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner;
    logic          found;
    logic          done;
    logic          launch;
    logic          timed_out;

    // Walk from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(last_grant) + k) % NREQ]) begin
                found  = 1'b1;
                winner = GW'((int'(last_grant) + k) % NREQ);
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign timed_out = !bus.Pready && (wait_cnt == CW'(TIMEOUT));

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS && !bus.Pready && !timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    assign done   = (state == ST_ACCESS) && (bus.Pready || timed_out);
    assign launch = found && ((state == ST_IDLE) || done);

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            state         <= ST_IDLE;
            grant         <= '0;
            last_grant    <= GW'(NREQ - 1);
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.Paddr     <= '0;
            bus.Pwrite    <= 1'b0;
            bus.Pwdata    <= '0;
            bus.Psel      <= 1'b0;
            bus.Penable   <= 1'b0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    bus.Psel    <= 1'b0;
                    bus.Penable <= 1'b0;
                end
                ST_SETUP: begin
                    state       <= ST_ACCESS;
                    bus.Psel    <= 1'b1;
                    bus.Penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (done) begin
                        bus.rsp_valid[grant] <= 1'b1;
                        // A timed-out transfer has no valid slave data, so it reports zero.
                        bus.rsp_rdata <= (bus.Pwrite || !bus.Pready) ? '0 : bus.Prdata;
                        bus.rsp_err   <= bus.Pready ? bus.Pslverr : 1'b1;
                        state         <= ST_IDLE;
                        bus.Psel      <= 1'b0;
                        bus.Penable   <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    bus.Psel    <= 1'b0;
                    bus.Penable <= 1'b0;
                end
            endcase

            // A new grant overrides the IDLE/ACCESS next-state above, giving back-to-back transfers.
            if (launch) begin
                state                 <= ST_SETUP;
                grant                 <= winner;
                last_grant            <= winner;
                bus.req_ready[winner] <= 1'b1;
                bus.Paddr             <= bus.req_addr[winner*ADDR_W +: ADDR_W];
                bus.Pwrite            <= bus.req_write[winner];
                bus.Pwdata            <= bus.req_wdata[winner*DATA_W +: DATA_W];
                bus.Psel              <= 1'b1;
                bus.Penable           <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;
    localparam int NREQ   = 2;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    typedef struct {
        int          req;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t sb[$];

    apb_master_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
        .Pclk (clk),
        .Prst (rst_n),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_exp(input int r, input logic [15:0] d, input logic e);
        exp_t x;
        x.req   = r;
        x.rdata = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, 32'(bus.rsp_valid), 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1 << e.req);
            chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(e.rdata));
            chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'(e.err));
        end
    endtask

    task automatic wait_rsp(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (bus.rsp_valid == '0 && n < max_cycles) begin
            step();
            n++;
        end
        check_rsp(tag);
    endtask

    task automatic set_req(input int r, input logic wr, input logic [2:0] a, input logic [15:0] d);
        bus.req_valid[r]            = 1'b1;
        bus.req_write[r]            = wr;
        bus.req_addr[r*ADDR_W +: ADDR_W] = a;
        bus.req_wdata[r*DATA_W +: DATA_W] = d;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.Prdata    = '0;
        bus.Pready    = 1'b1;
        bus.Pslverr   = 1'b0;
        step();
        step();
        chk("reset_psel",      32'(bus.Psel),      32'd0);
        chk("reset_penable",   32'(bus.Penable),   32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_paddr",     32'(bus.Paddr),     32'd0);
        chk("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: single write, zero wait states
        set_req(0, 1'b1, 3'b010, 16'h0009);
        push_exp(0, 16'h0000, 1'b0);
        step();
        chk("t1_setup_psel",    32'(bus.Psel),      32'd1);
        chk("t1_setup_penable", 32'(bus.Penable),   32'd0);
        chk("t1_req_ready",     32'(bus.req_ready), 32'b01);
        chk("t1_paddr",         32'(bus.Paddr),     32'd2);
        chk("t1_pwdata",        32'(bus.Pwdata),    32'h0009);
        chk("t1_pwrite",        32'(bus.Pwrite),    32'd1);
        bus.req_valid = '0;
        step();
        chk("t1_access_psel",    32'(bus.Psel),      32'd1);
        chk("t1_access_penable", 32'(bus.Penable),   32'd1);
        chk("t1_req_ready_drop", 32'(bus.req_ready), 32'd0);
        step();
        check_rsp("t1");
        chk("t1_idle_psel", 32'(bus.Psel), 32'd0);

        // 2: read with three wait states
        bus.Pready = 1'b0;
        bus.Prdata = 16'h0001;
        set_req(1, 1'b0, 3'b101, 16'hFFFF);
        push_exp(1, 16'h0001, 1'b0);
        step();
        chk("t2_req_ready", 32'(bus.req_ready), 32'b10);
        bus.req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("t2_wait%0d_paddr", c),   32'(bus.Paddr),     32'd5);
            chk($sformatf("t2_wait%0d_penable", c), 32'(bus.Penable),   32'd1);
            chk($sformatf("t2_wait%0d_rsp", c),     32'(bus.rsp_valid), 32'd0);
            if (c == 3) bus.Pready = 1'b1;
        end
        step();
        check_rsp("t2");

        // 3: both requesters hold valid -> alternating grants, no IDLE gap
        apply_reset();
        bus.Prdata = 16'h00AB;
        set_req(0, 1'b1, 3'b001, 16'h1234);
        set_req(1, 1'b0, 3'b110, 16'h0000);
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) push_exp(0, 16'h0000, 1'b0);
            else            push_exp(1, 16'h00AB, 1'b0);
        end
        for (int t = 0; t < 4; t++) begin
            step();
            if (t > 0) check_rsp($sformatf("t3_xfer%0d", t - 1));
            chk($sformatf("t3_grant%0d", t),   32'(bus.req_ready), (t % 2 == 0) ? 32'b01 : 32'b10);
            chk($sformatf("t3_paddr%0d", t),   32'(bus.Paddr),     (t % 2 == 0) ? 32'd1 : 32'd6);
            chk($sformatf("t3_setup_psel%0d", t), 32'(bus.Psel),   32'd1);
            chk($sformatf("t3_setup_pen%0d", t),  32'(bus.Penable), 32'd0);
            step();
            chk($sformatf("t3_access_pen%0d", t), 32'(bus.Penable), 32'd1);
            if (t == 3) bus.req_valid = '0;
        end
        step();
        check_rsp("t3_xfer3");
        chk("t3_idle_psel", 32'(bus.Psel), 32'd0);

        // 4: slave error, then a clean transfer
        bus.Pslverr = 1'b1;
        set_req(0, 1'b1, 3'b111, 16'h0007);
        push_exp(0, 16'h0000, 1'b1);
        step();
        bus.req_valid = '0;
        step();
        step();
        check_rsp("t4_err");
        bus.Pslverr = 1'b0;
        set_req(1, 1'b0, 3'b011, 16'h0000);
        push_exp(1, 16'h00AB, 1'b0);
        step();
        bus.req_valid = '0;
        step();
        step();
        check_rsp("t4_clean");

        // 5: reset during ACCESS, then priority restarts at requester 0
        bus.Pready = 1'b0;
        set_req(0, 1'b1, 3'b100, 16'h5555);
        step();
        bus.req_valid = '0;
        step();
        chk("t5_pre_psel", 32'(bus.Psel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_psel",      32'(bus.Psel),      32'd0);
        chk("t5_rst_penable",   32'(bus.Penable),   32'd0);
        chk("t5_rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        bus.Pready = 1'b1;
        set_req(0, 1'b0, 3'b001, 16'h0000);
        set_req(1, 1'b0, 3'b010, 16'h0000);
        push_exp(0, 16'h00AB, 1'b0);
        push_exp(1, 16'h00AB, 1'b0);
        step();
        step();
        chk("t5_held_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("t5_first_grant", 32'(bus.req_ready), 32'b01);
        bus.req_valid[0] = 1'b0;
        step();
        step();
        check_rsp("t5_req0");
        chk("t5_second_grant", 32'(bus.req_ready), 32'b10);
        bus.req_valid = '0;
        step();
        step();
        check_rsp("t5_req1");

        // 6: slave never ready
        bus.Pready = 1'b0;
        set_req(1, 1'b0, 3'b000, 16'h0000);
        step();
        bus.req_valid = '0;
`ifdef APB_TIMEOUT_EN
        push_exp(1, 16'h0000, 1'b1);
        n = 0;
        while (bus.rsp_valid == '0 && n < 40) begin
            step();
            n++;
        end
        chk("t6_timeout_latency", 32'(n), 32'd17);
        check_rsp("t6_timeout");
        bus.Pready = 1'b1;
`else
        n = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.rsp_valid != '0) n++;
        end
        chk("t6_no_completion", 32'(n), 32'd0);
        chk("t6_still_access", 32'(bus.Penable), 32'd1);
        bus.Pready = 1'b1;
        push_exp(1, 16'h00AB, 1'b0);
        wait_rsp("t6_release", 5);
`endif
        chk("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
